// File: rtl/bsg_link_arb_pkg.sv
// bsg_link_arb_pkg: shared FSM state type and credit-counter width helper
package bsg_link_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/bsg_link_upstream_arbiter_if.sv
// bsg_link_upstream_arbiter_if: requester, link and credit signals of the arbiter
// slave  : arbiter side (takes req_*_i, link_ready_i, token_i; drives the _o signals)
// master : environment side (requesters, upstream link, token source)
interface bsg_link_upstream_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int CREDITS = 16
) ();
    import bsg_link_arb_pkg::*;

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = credit_width(CREDITS);

    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ*WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]       req_last_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic                     link_valid_o;
    logic [WIDTH-1:0]         link_data_o;
    logic                     link_ready_i;
    logic                     token_i;
    logic [CNT_W-1:0]         credit_cnt_o;
    logic [ID_W-1:0]          grant_id_o;
    logic                     credit_err_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, link_ready_i, token_i,
        output req_ready_o, link_valid_o, link_data_o, credit_cnt_o, grant_id_o, credit_err_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, link_ready_i, token_i,
        input  req_ready_o, link_valid_o, link_data_o, credit_cnt_o, grant_id_o, credit_err_o
    );

endinterface

// File: rtl/bsg_link_rr_picker.sv
// bsg_link_rr_picker: first valid requester at or after ptr_i, wrapping
// valid_i : request vector      ptr_i : round-robin start position
// grant_o : one-hot winner      id_o  : winner index (ptr_i when none valid)
// any_o   : some requester valid
module bsg_link_rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    id_o,
    output logic               any_o
);
    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        idx = '0;
        id_o = ptr_i;
        any_o = |valid_i;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            id_o = valid_i[idx] ? idx : id_o;
        end
        grant_o = '0;
        grant_o[id_o] = any_o;
    end

endmodule

// File: rtl/bsg_link_upstream_arbiter.sv
// bsg_link_upstream_arbiter: round-robin, message-locked, credit-gated mux onto one upstream link
// clk, rst_n : core clock, asynchronous active-low reset
// bus        : requester handshakes, registered link output, token input, credit/grant status
module bsg_link_upstream_arbiter
    import bsg_link_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int WIDTH         = 64,
    parameter int CREDITS       = 16,
    parameter int LG_DECIMATION = 3
) (
    input logic clk,
    input logic rst_n,
    bsg_link_upstream_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int CNT_W = credit_width(CREDITS);
    localparam logic [31:0] RETURN = 32'd1 << LG_DECIMATION;

    state_e state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d, lock_q, lock_d, pick_id, sel_id;
    logic [NUM_REQ-1:0] pick_grant, grant, ready;
    logic pick_any, out_free, can_load, load, sel_last;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic err_q, err_d, valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [31:0] credit_sum;

    bsg_link_rr_picker #(.NUM_REQ(NUM_REQ)) picker (
        .valid_i(bus.req_valid_i),
        .ptr_i  (ptr_q),
        .grant_o(pick_grant),
        .id_o   (pick_id),
        .any_o  (pick_any)
    );

    always_comb begin
        sel_id = state_q == LOCKED ? lock_q : pick_id;
        grant = state_q == LOCKED ? '0 : pick_grant;
        grant[lock_q] = grant[lock_q] | (state_q == LOCKED);
        out_free = ~valid_q | bus.link_ready_i;
        can_load = out_free & (cnt_q != '0);
        ready = {NUM_REQ{can_load}} & grant & bus.req_valid_i;
        load = |ready;
        sel_last = bus.req_last_i[sel_id];
        state_d = state_q;
        ptr_d = ptr_q;
        lock_d = lock_q;
        if (load & sel_last) begin
            state_d = IDLE;
            ptr_d = sel_id == ID_W'(NUM_REQ - 1) ? '0 : sel_id + 1'b1;
        end else if (load) begin
            state_d = LOCKED;
            lock_d = sel_id;
        end
        valid_d = load | (valid_q & ~bus.link_ready_i);
        data_d = load ? bus.req_data_i[sel_id*WIDTH +: WIDTH] : data_q;
        // Credits are spent at load time; a token in the same cycle still adds.
        credit_sum = 32'(cnt_q) - 32'(load) + (bus.token_i ? RETURN : 32'd0);
        cnt_d = credit_sum > CREDITS ? CNT_W'(CREDITS) : CNT_W'(credit_sum);
        err_d = err_q | (credit_sum > CREDITS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q <= '0;
            lock_q <= '0;
            cnt_q <= CNT_W'(CREDITS);
            err_q <= 1'b0;
            valid_q <= 1'b0;
            data_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            lock_q <= lock_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            valid_q <= valid_d;
            data_q <= data_d;
        end
    end

    // Combinational outputs are forced to their idle values while reset is held.
    assign bus.req_ready_o = rst_n ? ready : '0;
    assign bus.grant_id_o = rst_n ? sel_id : '0;
    assign bus.link_valid_o = valid_q;
    assign bus.link_data_o = data_q;
    assign bus.credit_cnt_o = cnt_q;
    assign bus.credit_err_o = err_q;

endmodule

// File: doc/bsg_link_upstream_arbiter.md
Name: bsg_link_upstream_arbiter

Overview:
- Shares one bsg_link_ddr_upstream core-side port among NUM_REQ core requesters.
- Round-robin arbitration at message granularity: a grant is held until the requester's last flit.
- Sender-side credit counter, replenished by decimated token pulses, gates every flit.
- One registered output stage drives the upstream link's core_valid_i/core_data_i and accepts its core_ready_o.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 64, flit width; equals upstream core_data_i width.
- CREDITS, 16, initial and maximum credit count (buffer depth at receiver).
- LG_DECIMATION, 3, each token pulse returns 2^LG_DECIMATION credits.

Ports:
- clk  in  1  single clock (upstream core clock).
- rst_n  in  1  asynchronous, active-low reset.
- req_valid_i  in  NUM_REQ  per-requester flit valid.
- req_data_i  in  NUM_REQ*WIDTH  flits, requester i at bits [i*WIDTH +: WIDTH].
- req_last_i  in  NUM_REQ  flit is final of its message.
- req_ready_o  out  NUM_REQ  flit accepted this cycle when valid&ready.
- link_valid_o  out  1  to upstream core_valid_i.
- link_data_o  out  WIDTH  to upstream core_data_i.
- link_ready_i  in  1  from upstream core_ready_o.
- token_i  in  1  one-cycle credit-return pulse, already synchronized to clk.
- credit_cnt_o  out  $clog2(CREDITS+1)  current credits.
- grant_id_o  out  $clog2(NUM_REQ)  requester currently granted/locked.
- credit_err_o  out  1  sticky: credit overflow occurred.

Behaviour:
- Interface decided: one clock, clk; reset rst_n, asynchronous and active-low.
- Reset values: link_valid_o=0, link_data_o=0, req_ready_o=0, credit_cnt_o=CREDITS, grant_id_o=0, credit_err_o=0; rr pointer=0; state=IDLE.
- Output register: out_free = ~link_valid_o | link_ready_i. Link transfer = link_valid_o & link_ready_i.
- can_load = out_free & (credit_cnt != 0).
- req_ready_o[i] = can_load & grant[i] & req_valid_i[i], where grant is one-hot. Accepted flit appears on link_valid_o/link_data_o the next cycle (latency 1).
- Full throughput: one flit per cycle while link_ready_i=1 and credits>0.
- No load, but a transfer: link_valid_o falls to 0 next cycle. link_data_o holds its value while link_valid_o=1 & ~link_ready_i.
- FSM IDLE:
  - grant = first valid requester at or after the rr pointer, wrapping modulo NUM_REQ.
  - Accept with last=1: stay IDLE, pointer <= winner+1 (mod NUM_REQ).
  - Accept with last=0: go LOCKED, lock_id <= winner.
- FSM LOCKED:
  - grant only lock_id; other requesters see ready=0 even if credits exist.
  - Accept with last=1: go IDLE, pointer <= lock_id+1.
  - A locked requester that drops valid keeps the lock; no timeout.
- grant_id_o: lock_id in LOCKED; in IDLE, the combinational winner, or the pointer if no requester is valid.
- Credits:
  - next = cnt - load + (token_i ? 2^LG_DECIMATION : 0); load and token in the same cycle both apply.
  - If next > CREDITS: saturate at CREDITS and set credit_err_o (sticky until reset).
  - Count never underflows, because load requires cnt != 0.
  - Credits are consumed at load, not at link transfer.
- Reset mid-message clears the lock, the output register and credits immediately; no partial flit survives.

Decomposition:
- Shared package bsg_link_arb_pkg: FSM state enum {IDLE, LOCKED}; function for credit-width calculation.
- Sub-module bsg_link_rr_picker: combinational round-robin pick from valid vector and pointer, output one-hot plus encoded id. Instantiated once; the FSM, credit counter and output register stay in the top.

Test Plan:
- Reset, then req_valid_i=4'b0001 with last=1, link_ready_i=1: req_ready_o[0]=1 in cycle 0. Next cycle link_valid_o=1, link_data_o=req0 data, credit_cnt_o=15.
- All four requesters continuously valid with single-flit messages, link_ready_i=1: grants in order 0,1,2,3,0; credit_cnt_o goes 16→12 after 4 flits.
- Requester 1 sends a 3-flit message (last on flit 3) while requester 2 is valid: requester 2 is not granted until the cycle after the last flit of 1; pointer then points to 2.
- With no tokens, send 16 flits: credit_cnt_o=0 and all req_ready_o=0. One token_i pulse gives credit_cnt_o=8, and sending resumes the next cycle.
- link_ready_i=0 for 5 cycles with link_valid_o=1: link_data_o stable, no req_ready_o, credits unchanged. On release, back-to-back transfer resumes.
- token_i pulse at credit_cnt_o=12: counter saturates at 16 and credit_err_o=1. rst_n low mid-LOCKED: all outputs at reset values asynchronously.
